instr_sequencer: RTL and testbench

Program-buffer and run controller for the 8-bit single-cycle processor core. Accepts an instruction stream over a valid/ready load port into a local program RAM. Resets the core, then feeds it `instruction` indexed by the core's `pcOut`. Each executed cycle is qualified with a `cpu_step` enable. Supports free-run and single-step modes, end-of-program detection, a step watchdog, and abort.

---
 rtl/instr_sequencer_pkg.sv | 20 ++
 rtl/prog_ram.sv | 28 ++
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 tb/tb_instr_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its program RAM.
// The SEQ_HALT_ON_OVF_EN build macro selects whether the HALT state is used.
package seq_pkg;

  localparam int INSTR_W = 8;
  localparam int PC_W    = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_RST = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    HALT    = 3'd4
  } seqState_t;

  function automatic logic isBusy(input seqState_t s);
    return (s == CPU_RST) || (s == RUN);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program buffer: DEPTH x INSTR_W storage, one synchronous write port and one
// asynchronous read port so the core sees its instruction in the same cycle.
module prog_ram
  import seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wrEn,
  input  logic [ADDR_W-1:0]  wrAddr,
  input  logic [INSTR_W-1:0] wrData,
  input  logic [ADDR_W-1:0]  rdAddr,
  output logic [INSTR_W-1:0] rdData
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset; a stored program survives reset.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_sequencer.sv
// Program-buffer and run controller for the 8-bit core: loads a program, resets
// the core, then steps it. Build macro SEQ_HALT_ON_OVF_EN enables halt-on-overflow.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int MAX_STEPS = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               clear,
  input  logic               start,
  input  logic               abort,
  input  logic               step_mode,
  input  logic               step,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               overflow_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic               cpu_step,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               ovf_seen,
  output logic [ADDR_W:0]    prog_len,
  output seqState_t          stateDbg
);

  localparam int CMP_W = PC_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [15:0]     LAST_CNT = 16'(MAX_STEPS - 1);

  seqState_t          state;
  logic [ADDR_W:0]    progLen;
  logic [15:0]        stepCnt;
  logic               timeoutQ;
  logic               ovfQ;

  logic               isFull;
  logic               loadFire;
  logic               pcInRange;
  logic               lastStep;
  logic [INSTR_W-1:0] ramData;

  // Load port handshake: a beat transfers on a rising clk edge where
  // load_valid && load_ready are both high; the producer holds load_data
  // stable while load_valid is high and load_ready is low. Ready never
  // waits on valid, and it drops when full, outside IDLE, or during clear.
  assign isFull     = (progLen == DEPTH_L);
  assign load_ready = !reset && (state == IDLE) && !isFull && !clear;
  assign loadFire   = load_valid && load_ready;

  // The range check uses the whole pc so an out-of-range pc never aliases.
  assign pcInRange = (CMP_W'(pc_in) < CMP_W'(progLen));
  assign lastStep  = (stepCnt == LAST_CNT);

  assign cpu_step  = !reset && (state == RUN) && !abort && pcInRange &&
                     (!step_mode || step);
  assign instr_out = (!reset && (state == RUN) && pcInRange) ? ramData : '0;
  assign cpu_reset = reset || (state == IDLE) || (state == CPU_RST);
  assign busy      = !reset && isBusy(state);
  assign done      = !reset && ((state == DONE) || (state == HALT));
  assign timeout   = timeoutQ;
  assign ovf_seen  = ovfQ;
  assign prog_len  = progLen;
  assign stateDbg  = state;

  prog_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_prog_ram (
    .clk    (clk),
    .wrEn   (loadFire),
    .wrAddr (progLen[ADDR_W-1:0]),
    .wrData (load_data),
    .rdAddr (pc_in[ADDR_W-1:0]),
    .rdData (ramData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      progLen  <= '0;
      stepCnt  <= '0;
      timeoutQ <= 1'b0;
      ovfQ     <= 1'b0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            progLen <= '0;
          end else begin
            if (loadFire) begin
              progLen <= progLen + LEN_ONE;
            end
            // A beat accepted alongside start is part of this run.
            if (start && ((progLen != '0) || loadFire)) begin
              state <= CPU_RST;
            end
          end
        end
        CPU_RST: begin
          stepCnt  <= '0;
          timeoutQ <= 1'b0;
          ovfQ     <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          if (cpu_step) begin
            stepCnt <= stepCnt + 16'd1;
            if (lastStep) begin
              timeoutQ <= 1'b1;
              state    <= DONE;
            end
            if (overflow_in) begin
              ovfQ <= 1'b1;
`ifdef SEQ_HALT_ON_OVF_EN
              state <= HALT;
`endif
            end
          end else if (!pcInRange) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (clear) begin
            progLen <= '0;
            state   <= IDLE;
          end else if (start) begin
            state <= CPU_RST;
          end
        end
`ifdef SEQ_HALT_ON_OVF_EN
        HALT: begin
          if (clear) begin
            progLen <= '0;
            state   <= IDLE;
          end else if (start) begin
            state <= CPU_RST;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a tiny core model driving pc_in.
// Runs with MAX_STEPS=4 so the watchdog is reachable with short programs.
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int MAX_STEPS = 4;

  logic              clk;
  logic              reset;
  logic              load_valid;
  logic              load_ready;
  logic [7:0]        load_data;
  logic              clear;
  logic              start;
  logic              abort;
  logic              step_mode;
  logic              step;
  logic [7:0]        pc_in;
  logic              overflow_in;
  logic [7:0]        instr_out;
  logic              cpu_step;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              timeout;
  logic              ovf_seen;
  logic [ADDR_W:0]   prog_len;
  seqState_t         stateDbg;

  logic [7:0]        pcModel;
  logic              loopPc;
  logic              ovfEn;
  logic [7:0]        exp_q[$];

  int nCompared;
  int nMismatch;

  instr_sequencer #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .clear       (clear),
    .start       (start),
    .abort       (abort),
    .step_mode   (step_mode),
    .step        (step),
    .pc_in       (pc_in),
    .overflow_in (overflow_in),
    .instr_out   (instr_out),
    .cpu_step    (cpu_step),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .ovf_seen    (ovf_seen),
    .prog_len    (prog_len),
    .stateDbg    (stateDbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: pc returns to 0 under reset and advances once per executed step.
  always @(posedge clk) begin
    if (cpu_reset) pcModel <= 8'd0;
    else if (cpu_step && !loopPc) pcModel <= pcModel + 8'd1;
  end
  assign pc_in       = pcModel;
  assign overflow_in = ovfEn && (pcModel == 8'd1);

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic loadProgram(input logic [7:0] base, input int n);
    load_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      load_data = base + 8'(i);
      nextCyc();
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 0; load_data = 0; clear = 0; start = 0; abort = 0;
    step_mode = 0; step = 0; loopPc = 0; ovfEn = 0;
    nextCyc(); nextCyc();
    load_valid = 1'b1;
    @(negedge clk);
    nCompared++; if (load_ready !== 1'b0) begin nMismatch++; $display("FAIL rst_load_ready: got %b want 0", load_ready); end
    nCompared++; if (cpu_step !== 1'b0) begin nMismatch++; $display("FAIL rst_cpu_step: got %b want 0", cpu_step); end
    nCompared++; if ({done, busy} !== 2'b00) begin nMismatch++; $display("FAIL rst_done_busy: got %b want 00", {done, busy}); end
    nCompared++; if (cpu_reset !== 1'b1) begin nMismatch++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    nextCyc();
    reset = 1'b0; load_valid = 1'b0;
    @(negedge clk);
    nCompared++; if (prog_len !== 5'd0) begin nMismatch++; $display("FAIL rst_prog_len: got %0d want 0", prog_len); end
    nCompared++; if ({timeout, ovf_seen} !== 2'b00) begin nMismatch++; $display("FAIL rst_flags: got %b want 00", {timeout, ovf_seen}); end
    nCompared++; if (stateDbg !== IDLE) begin nMismatch++; $display("FAIL rst_state: got %0d want IDLE", stateDbg); end
    nCompared++; if (load_ready !== 1'b1) begin nMismatch++; $display("FAIL idle_load_ready: got %b want 1", load_ready); end
    nextCyc();
  endtask

  task automatic test_load_run();
    int nSteps;
    int stepBad;
    logic [7:0] e;
    exp_q = {8'h41, 8'h52, 8'hC3};
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_data = exp_q[i];
      @(negedge clk);
      nCompared++; if (load_ready !== 1'b1) begin nMismatch++; $display("FAIL load_ready_beat%0d: got %b want 1", i, load_ready); end
      nextCyc();
    end
    load_valid = 1'b0;
    @(negedge clk);
    nCompared++; if (prog_len !== 5'd3) begin nMismatch++; $display("FAIL load_prog_len: got %0d want 3", prog_len); end
    start = 1'b1; nextCyc(); start = 1'b0;
    @(negedge clk);
    nCompared++; if (stateDbg !== CPU_RST) begin nMismatch++; $display("FAIL run_cpu_rst_state: got %0d want CPU_RST", stateDbg); end
    nCompared++; if ({cpu_reset, cpu_step, busy} !== 3'b101) begin nMismatch++; $display("FAIL run_cpu_rst_outs: got %b want 101", {cpu_reset, cpu_step, busy}); end
    nextCyc();
    nSteps = 0; stepBad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) break;
      if (i == 0) begin
        nCompared++; if (cpu_step !== 1'b1) begin nMismatch++; $display("FAIL start_latency: got cpu_step %b want 1", cpu_step); end
      end
      if (cpu_reset !== 1'b0) stepBad++;
      if (pc_in == 8'd3 && cpu_step !== 1'b0) stepBad++;
      if (cpu_step) begin
        nSteps++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          nCompared++; if (instr_out !== e) begin nMismatch++; $display("FAIL run_instr_out: got %h want %h", instr_out, e); end
        end
      end
      nextCyc();
    end
    nCompared++; if (nSteps != 3) begin nMismatch++; $display("FAIL run_step_count: got %0d want 3", nSteps); end
    nCompared++; if (stepBad != 0) begin nMismatch++; $display("FAIL run_reset_or_end_step: got %0d bad cycles want 0", stepBad); end
    nCompared++; if ({done, cpu_reset, timeout} !== 3'b100) begin nMismatch++; $display("FAIL run_done_level: got %b want 100", {done, cpu_reset, timeout}); end
    nextCyc();
  endtask

  task automatic test_full_buffer();
    int nSteps;
    clear = 1'b1; nextCyc(); clear = 1'b0;
    @(negedge clk);
    nCompared++; if (stateDbg !== IDLE || prog_len !== 5'd0) begin nMismatch++; $display("FAIL clear_from_done: got state %0d len %0d want IDLE 0", stateDbg, prog_len); end
    nextCyc();
    loadProgram(8'h10, DEPTH);
    load_valid = 1'b1; load_data = 8'hEE;
    @(negedge clk);
    nCompared++; if (load_ready !== 1'b0) begin nMismatch++; $display("FAIL full_load_ready: got %b want 0", load_ready); end
    nextCyc(); nextCyc();
    load_valid = 1'b0;
    @(negedge clk);
    nCompared++; if (prog_len !== 5'd16) begin nMismatch++; $display("FAIL full_prog_len: got %0d want 16", prog_len); end
    start = 1'b1; nextCyc(); start = 1'b0; nextCyc();
    nSteps = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) break;
      if (i == 0) begin
        nCompared++; if (instr_out !== 8'h10) begin nMismatch++; $display("FAIL full_entry0_intact: got %h want 10", instr_out); end
      end
      if (cpu_step) nSteps++;
      nextCyc();
    end
    nCompared++; if (nSteps != MAX_STEPS) begin nMismatch++; $display("FAIL full_watchdog_steps: got %0d want %0d", nSteps, MAX_STEPS); end
    nCompared++; if ({done, timeout} !== 2'b11) begin nMismatch++; $display("FAIL full_timeout: got %b want 11", {done, timeout}); end
    nextCyc();
  endtask

  task automatic test_watchdog();
    int nSteps;
    loopPc = 1'b1;
    start = 1'b1; nextCyc(); start = 1'b0; nextCyc();
    @(negedge clk);
    nCompared++; if (timeout !== 1'b0) begin nMismatch++; $display("FAIL wd_start_clears_timeout: got %b want 0", timeout); end
    nSteps = 0;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      if (done) break;
      if (cpu_step) nSteps++;
      nextCyc();
    end
    loopPc = 1'b0;
    nCompared++; if (nSteps != MAX_STEPS) begin nMismatch++; $display("FAIL wd_steps: got %0d want %0d", nSteps, MAX_STEPS); end
    nCompared++; if ({stateDbg == DONE, timeout} !== 2'b11) begin nMismatch++; $display("FAIL wd_done_timeout: got state %0d timeout %b want DONE 1", stateDbg, timeout); end
    nextCyc();
  endtask

  task automatic test_step_mode();
    int extraSteps;
    clear = 1'b1; nextCyc(); clear = 1'b0;
    loadProgram(8'hA0, 3);
    step_mode = 1'b1; step = 1'b1;
    @(negedge clk);
    nCompared++; if (cpu_step !== 1'b0 || stateDbg !== IDLE) begin nMismatch++; $display("FAIL step_in_idle: got step %b state %0d want 0 IDLE", cpu_step, stateDbg); end
    nextCyc(); step = 1'b0;
    start = 1'b1; nextCyc(); start = 1'b0; nextCyc();
    extraSteps = 0;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 5; k++) begin
        step = (k == 0);
        @(negedge clk);
        if (k == 0) begin
          nCompared++; if (cpu_step !== 1'b1 || instr_out !== (8'hA0 + 8'(p))) begin nMismatch++; $display("FAIL step_pulse%0d: got step %b instr %h want 1 %h", p, cpu_step, instr_out, 8'hA0 + 8'(p)); end
        end else if (cpu_step !== 1'b0) begin
          extraSteps++;
        end
        nextCyc();
      end
    end
    step = 1'b0;
    nCompared++; if (extraSteps != 0) begin nMismatch++; $display("FAIL step_between_pulses: got %0d steps want 0", extraSteps); end
    @(negedge clk);
    nCompared++; if ({done, timeout} !== 2'b10) begin nMismatch++; $display("FAIL step_done: got %b want 10", {done, timeout}); end
    step_mode = 1'b0;
    nextCyc();
  endtask

  task automatic test_overflow();
    int nSteps;
    ovfEn = 1'b1;
    start = 1'b1; nextCyc(); start = 1'b0; nextCyc();
    nSteps = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) break;
      if (cpu_step) nSteps++;
      nextCyc();
    end
    ovfEn = 1'b0;
    nCompared++; if (ovf_seen !== 1'b1) begin nMismatch++; $display("FAIL ovf_seen: got %b want 1", ovf_seen); end
`ifdef SEQ_HALT_ON_OVF_EN
    nCompared++; if (nSteps != 2) begin nMismatch++; $display("FAIL ovf_halt_steps: got %0d want 2", nSteps); end
    nCompared++; if (stateDbg !== HALT || done !== 1'b1) begin nMismatch++; $display("FAIL ovf_halt_state: got %0d done %b want HALT 1", stateDbg, done); end
`else
    nCompared++; if (nSteps != 3) begin nMismatch++; $display("FAIL ovf_run_steps: got %0d want 3", nSteps); end
    nCompared++; if (stateDbg !== DONE || done !== 1'b1) begin nMismatch++; $display("FAIL ovf_run_state: got %0d done %b want DONE 1", stateDbg, done); end
`endif
    nextCyc();
  endtask

  task automatic test_abort();
    ovfEn = 1'b1;
    start = 1'b1; nextCyc(); start = 1'b0;
    nextCyc(); nextCyc(); nextCyc();
    abort = 1'b1; nextCyc(); abort = 1'b0; ovfEn = 1'b0;
    @(negedge clk);
    nCompared++; if (stateDbg !== IDLE || busy !== 1'b0) begin nMismatch++; $display("FAIL abort_to_idle: got state %0d busy %b want IDLE 0", stateDbg, busy); end
    nCompared++; if (prog_len !== 5'd3 || ovf_seen !== 1'b1) begin nMismatch++; $display("FAIL abort_retained: got len %0d ovf %b want 3 1", prog_len, ovf_seen); end
    start = 1'b1; nextCyc(); start = 1'b0;
    @(negedge clk);
    nCompared++; if (stateDbg !== CPU_RST || cpu_reset !== 1'b1) begin nMismatch++; $display("FAIL abort_rerun: got state %0d rst %b want CPU_RST 1", stateDbg, cpu_reset); end
    nextCyc();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) break;
      nextCyc();
    end
    nCompared++; if ({done, ovf_seen} !== 2'b10) begin nMismatch++; $display("FAIL abort_rerun_done: got %b want 10", {done, ovf_seen}); end
    nextCyc();
  endtask

  task automatic test_back_to_back();
    clear = 1'b1; start = 1'b1; nextCyc(); clear = 1'b0; start = 1'b0;
    @(negedge clk);
    nCompared++; if (stateDbg !== IDLE || prog_len !== 5'd0) begin nMismatch++; $display("FAIL clear_beats_start: got state %0d len %0d want IDLE 0", stateDbg, prog_len); end
    start = 1'b1; nextCyc(); start = 1'b0;
    @(negedge clk);
    nCompared++; if (stateDbg !== IDLE || busy !== 1'b0) begin nMismatch++; $display("FAIL start_empty: got state %0d busy %b want IDLE 0", stateDbg, busy); end
    load_valid = 1'b1; load_data = 8'h5A; start = 1'b1;
    nextCyc(); load_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    nCompared++; if (stateDbg !== CPU_RST || prog_len !== 5'd1) begin nMismatch++; $display("FAIL beat_with_start: got state %0d len %0d want CPU_RST 1", stateDbg, prog_len); end
    nextCyc();
    @(negedge clk);
    nCompared++; if (cpu_step !== 1'b1 || instr_out !== 8'h5A) begin nMismatch++; $display("FAIL beat_with_start_exec: got step %b instr %h want 1 5a", cpu_step, instr_out); end
    nextCyc();
    @(negedge clk);
    nCompared++; if (cpu_step !== 1'b0 || instr_out !== 8'h00) begin nMismatch++; $display("FAIL past_end: got step %b instr %h want 0 00", cpu_step, instr_out); end
    nextCyc();
    @(negedge clk);
    nCompared++; if (done !== 1'b1) begin nMismatch++; $display("FAIL single_done: got %b want 1", done); end
    nextCyc();
  endtask

  initial begin
    nCompared = 0;
    nMismatch = 0;
    test_reset();
    test_load_run();
    test_full_buffer();
    test_watchdog();
    test_step_mode();
    test_overflow();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
